// File: rtl/alu_serial_rx_if.sv
// rtl/alu_serial_rx_if.sv - result buffer bus between the serial receiver and the ALU core
interface alu_serial_rx_if #(
  parameter int WORD_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_a;
  logic [WORD_W-1:0] out_b;
  logic [2:0]        out_op;
  logic [3:0]        out_crc;
  logic              out_err_data;
  logic              out_err_crc;

  modport master (
    output out_valid, out_a, out_b, out_op, out_crc, out_err_data, out_err_crc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_a, out_b, out_op, out_crc, out_err_data, out_err_crc,
    output out_ready
  );
endinterface

// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - serial frame deserializer feeding the ALU core; CRC check under ALU_RX_CRC_CHECK_EN
module alu_serial_rx #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sin,
  alu_serial_rx_if.master out_if,
  output logic            frame_err,
  output logic            overflow
);
  localparam int NFR = 2 * WORD_W / 8;
  localparam int CW  = $clog2(NFR + 1);
  localparam int TW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] FULL    = CW'(NFR);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, TYPE, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic                is_cmd_q, is_cmd_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       to_q, to_d;
  logic [2*WORD_W-1:0] ab_q, ab_d;
  logic                frame_err_q, frame_err_d;
  logic                overflow_q, overflow_d;

  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic [3:0]          crc_out_q, crc_out_d;
  logic                err_data_q, err_data_d;
  logic                err_crc_q, err_crc_d;

  logic                load;
  logic [WORD_W-1:0]   ld_a, ld_b;
  logic [2:0]          ld_op;
  logic [3:0]          ld_crc;
  logic                ld_err_data, ld_err_crc;

`ifdef ALU_RX_CRC_CHECK_EN
  logic [3:0] crc_q, crc_d;

  // One MSB-first step of CRC-4, polynomial x^4+x+1.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction
`endif

  // Frame FSM next state, packet assembly, timeout and result generation.
  always_comb begin
    state_d     = state_q;
    is_cmd_d    = is_cmd_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    ab_d        = ab_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    ld_a        = '0;
    ld_b        = '0;
    ld_op       = '0;
    ld_crc      = '0;
    ld_err_data = 1'b0;
    ld_err_crc  = 1'b0;
`ifdef ALU_RX_CRC_CHECK_EN
    crc_d       = crc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = TYPE;
          to_d    = '0;
        end else if (TIMEOUT_CYC > 0 && cnt_q != '0) begin
          if (to_q == TO_LAST) begin
            cnt_d = '0;
            to_d  = '0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end else begin
          to_d = '0;
        end
      end
      TYPE: begin
        is_cmd_d = sin;
        bit_d    = 3'd0;
        state_d  = DATA;
`ifdef ALU_RX_CRC_CHECK_EN
        // A packet's checksum starts fresh with its first data frame.
        if (cnt_q == '0) crc_d = '0;
`endif
      end
      DATA: begin
        sh_d  = {sh_q[6:0], sin};
        bit_d = bit_q + 3'd1;
`ifdef ALU_RX_CRC_CHECK_EN
        // Command payload contributes the constant 1 (in place of bit 7) then op.
        if (!is_cmd_q)          crc_d = crc4_step(crc_q, sin);
        else if (bit_q == 3'd0) crc_d = crc4_step(crc_q, 1'b1);
        else if (bit_q <= 3'd3) crc_d = crc4_step(crc_q, sin);
`endif
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (!sin) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end else if (!is_cmd_q) begin
          if (cnt_q == FULL) begin
            cnt_d       = '0;
            load        = 1'b1;
            ld_err_data = 1'b1;
          end else begin
            ab_d  = {ab_q[2*WORD_W-9:0], sh_q};
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d  = '0;
          load   = 1'b1;
          ld_op  = sh_q[6:4];
          ld_crc = sh_q[3:0];
          if (cnt_q != FULL) begin
            ld_err_data = 1'b1;
          end else begin
            ld_a = ab_q[WORD_W-1:0];
            ld_b = ab_q[2*WORD_W-1:WORD_W];
`ifdef ALU_RX_CRC_CHECK_EN
            if (crc_q != sh_q[3:0]) begin
              ld_err_crc = 1'b1;
              ld_a       = '0;
              ld_b       = '0;
            end
`endif
          end
        end
      end
    endcase
  end

  // One-entry result buffer: drain on handshake, load unless full and stalled.
  always_comb begin
    valid_d    = valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    crc_out_d  = crc_out_q;
    err_data_d = err_data_q;
    err_crc_d  = err_crc_q;
    overflow_d = 1'b0;
    if (valid_q && out_if.out_ready) valid_d = 1'b0;
    if (load) begin
      if (valid_q && !out_if.out_ready) begin
        overflow_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        a_d        = ld_a;
        b_d        = ld_b;
        op_d       = ld_op;
        crc_out_d  = ld_crc;
        err_data_d = ld_err_data;
        err_crc_d  = ld_err_crc;
      end
    end
  end

  // State and output registers; reset discards any partial frame or packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_cmd_q    <= 1'b0;
      bit_q       <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      ab_q        <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      crc_out_q   <= '0;
      err_data_q  <= 1'b0;
      err_crc_q   <= 1'b0;
`ifdef ALU_RX_CRC_CHECK_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_cmd_q    <= is_cmd_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      ab_q        <= ab_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      crc_out_q   <= crc_out_d;
      err_data_q  <= err_data_d;
      err_crc_q   <= err_crc_d;
`ifdef ALU_RX_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign out_if.out_valid    = valid_q;
  assign out_if.out_a        = a_q;
  assign out_if.out_b        = b_q;
  assign out_if.out_op       = op_q;
  assign out_if.out_crc      = crc_out_q;
  assign out_if.out_err_data = err_data_q;
  assign out_if.out_err_crc  = err_crc_q;
  assign frame_err           = frame_err_q;
  assign overflow            = overflow_q;
endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - directed bench for alu_serial_rx; expectations follow ALU_RX_CRC_CHECK_EN
module tb_alu_serial_rx;
  logic clk = 1'b0;
  logic rst;
  logic sin;
  logic frame_err;
  logic overflow;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_serial_rx_if #(.WORD_W(32)) bus ();

  alu_serial_rx #(.WORD_W(32), .TIMEOUT_CYC(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_if    (bus),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of {B, A, 1, op} * x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    logic [71:0] v;
    v = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int first, input int n);
    logic [63:0] ba;
    ba = {b, a};
    for (int i = first; i < first + n; i++) send_frame(1'b0, ba[63-8*i -: 8], 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  // Called right after the final stop bit is driven; result must appear one cycle later.
  task automatic expect_res(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [2:0] eop, input logic [3:0] ecrc,
                            input logic ed, input logic ec);
    chk({tag, ".valid_early"}, 64'(bus.out_valid), 64'd0);
    send_bit(1'b1);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".a"}, 64'(bus.out_a), 64'(ea));
    chk({tag, ".b"}, 64'(bus.out_b), 64'(eb));
    chk({tag, ".op"}, 64'(bus.out_op), 64'(eop));
    chk({tag, ".crc"}, 64'(bus.out_crc), 64'(ecrc));
    chk({tag, ".err_data"}, 64'(bus.out_err_data), 64'(ed));
    chk({tag, ".err_crc"}, 64'(bus.out_err_crc), 64'(ec));
  endtask

  initial begin
    logic [3:0] c;
    rst = 1'b1;
    sin = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.valid", 64'(bus.out_valid), 64'd0);
    chk("reset.a", 64'(bus.out_a), 64'd0);
    chk("reset.frame_err", 64'(frame_err), 64'd0);
    chk("reset.overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    idle(3);

    // Good packet B=3, A=5, op=0.
    c = crc_model(32'd3, 32'd5, 3'b000);
    send_data(32'd3, 32'd5, 0, 8);
    send_cmd(3'b000, c);
    expect_res("t1", 32'd5, 32'd3, 3'b000, c, 1'b0, 1'b0);

    // Corrupted CRC field.
    send_data(32'd3, 32'd5, 0, 8);
    send_cmd(3'b000, c ^ 4'h1);
`ifdef ALU_RX_CRC_CHECK_EN
    expect_res("t2", 32'd0, 32'd0, 3'b000, c ^ 4'h1, 1'b0, 1'b1);
`else
    expect_res("t2", 32'd5, 32'd3, 3'b000, c ^ 4'h1, 1'b0, 1'b0);
`endif

    // Seven data frames then command, then a full packet.
    send_data(32'h0102_0304, 32'h0506_0708, 0, 7);
    send_cmd(3'b001, 4'h0);
    expect_res("t3.short", 32'd0, 32'd0, 3'b001, 4'h0, 1'b1, 1'b0);
    c = crc_model(32'd1, 32'd2, 3'b010);
    send_data(32'd1, 32'd2, 0, 8);
    send_cmd(3'b010, c);
    expect_res("t3.full", 32'd2, 32'd1, 3'b010, c, 1'b0, 1'b0);

    // Nine data frames: the ninth is reported as a data-count error.
    send_data(32'hdead_beef, 32'hcafe_f00d, 0, 8);
    send_frame(1'b0, 8'h5a, 1'b1);
    expect_res("extra", 32'd0, 32'd0, 3'b000, 4'h0, 1'b1, 1'b0);

    // Bad stop bit on the fourth data frame.
    send_data(32'haabb_ccdd, 32'h1122_3344, 0, 3);
    send_frame(1'b0, 8'hdd, 1'b0);
    send_bit(1'b1);
    chk("t4.frame_err", 64'(frame_err), 64'd1);
    chk("t4.no_valid", 64'(bus.out_valid), 64'd0);
    send_bit(1'b1);
    chk("t4.frame_err_pulse", 64'(frame_err), 64'd0);
    c = crc_model(32'haabb_ccdd, 32'h1122_3344, 3'b011);
    send_data(32'haabb_ccdd, 32'h1122_3344, 0, 8);
    send_cmd(3'b011, c);
    expect_res("t4.next", 32'h1122_3344, 32'haabb_ccdd, 3'b011, c, 1'b0, 1'b0);

    // Back-pressure: second packet overflows, first held.
    send_bit(1'b1);
    bus.out_ready = 1'b0;
    c = crc_model(32'h2222_2222, 32'h1111_1111, 3'b100);
    send_data(32'h2222_2222, 32'h1111_1111, 0, 8);
    send_cmd(3'b100, c);
    expect_res("t5.first", 32'h1111_1111, 32'h2222_2222, 3'b100, c, 1'b0, 1'b0);
    send_data(32'h4444_4444, 32'h3333_3333, 0, 8);
    send_cmd(3'b101, crc_model(32'h4444_4444, 32'h3333_3333, 3'b101));
    send_bit(1'b1);
    chk("t5.overflow", 64'(overflow), 64'd1);
    chk("t5.held_a", 64'(bus.out_a), 64'h1111_1111);
    chk("t5.held_op", 64'(bus.out_op), 64'd4);
    chk("t5.held_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    chk("t5.overflow_pulse", 64'(overflow), 64'd0);
    chk("t5.drained", 64'(bus.out_valid), 64'd0);

    // Reset mid-payload of the sixth data frame.
    send_data(32'h0a0b_0c0d, 32'h0e0f_1011, 0, 5);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6.rst_a", 64'(bus.out_a), 64'd0);
    chk("t6.rst_op", 64'(bus.out_op), 64'd0);
    chk("t6.rst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sin = 1'b1;
    idle(20);
    chk("t6.no_result", 64'(bus.out_valid), 64'd0);

    // Gap of one cycle under the timeout keeps the partial packet.
    c = crc_model(32'h7654_3210, 32'h89ab_cdef, 3'b110);
    send_data(32'h7654_3210, 32'h89ab_cdef, 0, 4);
    idle(254);
    send_data(32'h7654_3210, 32'h89ab_cdef, 4, 4);
    send_cmd(3'b110, c);
    expect_res("to.below", 32'h89ab_cdef, 32'h7654_3210, 3'b110, c, 1'b0, 1'b0);

    // Gap reaching the timeout discards the partial packet.
    send_data(32'hffff_0000, 32'h0000_ffff, 0, 4);
    idle(255);
    chk("to.no_result", 64'(bus.out_valid), 64'd0);
    c = crc_model(32'h0000_0007, 32'h0000_0009, 3'b111);
    send_data(32'h0000_0007, 32'h0000_0009, 0, 8);
    send_cmd(3'b111, c);
    expect_res("to.full", 32'd9, 32'd7, 3'b111, c, 1'b0, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
